game_countdown_timer: RTL
=========================

Name: game_countdown_timer

Overview:
Consumes the one-second pulse from the one-second timer and runs a two-digit BCD countdown of the seconds left in a game round. It drives the timer's enable so the one-second chain runs only while a countdown is active. It presents tens/ones digits to the seven-segment decoders and flags round expiry to the game controller FSM.

Parameters:
DEFAULT_TENS, 3, tens digit loaded when start_val is 00 or invalid (BCD 0-9)
DEFAULT_ONES, 0, ones digit loaded when start_val is 00 or invalid (BCD 0-9)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
one_sec  input  1  one-cycle pulse from the one-second timer, once per second while timer_en=1
start  input  1  one-cycle pulse; loads start_val and begins/restarts the countdown
abort  input  1  one-cycle pulse; stops the countdown and returns to idle
hold  input  1  level; freezes the countdown while high
start_val  input  8  BCD seconds to load, [7:4]=tens, [3:0]=ones
timer_en  output  1  enable to the one-second timer
sec_tens  output  4  BCD tens digit of seconds remaining
sec_ones  output  4  BCD ones digit of seconds remaining
running  output  1  high in RUN state
expired  output  1  level; high in EXPIRED state
expire_pulse  output  1  one-cycle pulse on entry to EXPIRED

Behaviour:
- All outputs are registered. Reset is asynchronous on rst low. Reset state is IDLE with sec_tens=DEFAULT_TENS, sec_ones=DEFAULT_ONES, and timer_en, running, expired and expire_pulse all 0.
- States: IDLE, RUN, PAUSE, EXPIRED (2-bit encoding).
- Input priority within one cycle: abort > start > hold > one_sec.
- IDLE:
  - start -> RUN, with the load rule applied.
  - Digits hold their value.
- Load rule: if either start_val nibble is >9, or start_val==8'h00, load DEFAULT_TENS/DEFAULT_ONES. Otherwise load start_val.
- RUN:
  - timer_en=1 and running=1, both registered; they assert the cycle after start.
  - On one_sec=1, decrement the BCD value: if ones!=0, ones-1; else ones=9 and tens-1.
  - Decrement from 01 -> 00 enters EXPIRED in the same clock edge that writes 00.
  - hold=1 -> PAUSE. A one_sec coincident with hold is dropped.
  - start -> reload per the load rule and stay in RUN; a coincident one_sec is ignored.
  - abort -> IDLE; digits retain their current value.
- PAUSE:
  - timer_en=0 and running=0; digits frozen; one_sec ignored.
  - hold=0 -> RUN.
  - start -> reload and go to RUN, even if hold is still 1; hold is re-evaluated next cycle.
  - abort -> IDLE.
- EXPIRED:
  - Digits=00, timer_en=0, expired=1.
  - expire_pulse=1 for exactly the first cycle in EXPIRED.
  - start -> RUN with reload. abort -> IDLE.
  - one_sec ignored; no wrap to 99 under any input.
- Latency: the digit change is visible the cycle after the one_sec pulse. expired/expire_pulse are visible the cycle after the final one_sec.
- Digits never leave the BCD range 0-9. Tens never underflows; 00 is terminal.
- Because timer_en drops when RUN is left, the upstream chain stops. A stray one_sec pulse arriving after that point is harmless because it is ignored outside RUN.
- Reset mid-countdown returns immediately to the reset state; no expire_pulse is generated.

Decomposition:
- Shared package: state encodings (ST_IDLE=2'b00, ST_RUN=2'b01, ST_PAUSE=2'b10, ST_EXPIRED=2'b11) and the BCD digit width constant (4).
- One sub-module is natural: bcd_down_counter_2d.
  - Ports: clk, rst, load, load_tens, load_ones, dec, tens, ones, zero.
  - Performs the two-digit BCD decrement with borrow and saturates at 00.
- The FSM, load-rule validation and output registers live in game_countdown_timer.

Test Plan:
1. Reset, then start with start_val=8'h05, then 5 one_sec pulses -> digits step 04,03,02,01,00. expire_pulse is high for 1 cycle after the 5th pulse, expired stays 1, and timer_en falls to 0.
2. start_val=8'h10, 1 one_sec -> digits 09 (ones borrow); 9 more pulses -> 00 and EXPIRED.
3. start_val=8'h00, and separately start_val=8'h3C -> load 30 (DEFAULT_TENS/ONES) in both cases.
4. In RUN at 25: hold=1 with 3 one_sec pulses -> digits stay 25 and timer_en=0. Release hold, 1 pulse -> 24.
5. Same cycle as one_sec, with abort and start both high -> IDLE, digits unchanged, running=0. Also start+one_sec in RUN -> reload and no decrement.
6. In EXPIRED, one_sec pulses -> digits stay 00 with no wrap. Then start with 8'h02 -> RUN at 02. Assert rst mid-count -> immediate reset state, expire_pulse never asserts.

Source files
------------

// File: rtl/game_countdown_timer_pkg.sv
// Shared definitions for the game round countdown: FSM state encoding and the
// BCD digit width.
package game_countdown_timer_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_PAUSE   = 2'b10,
    ST_EXPIRED = 2'b11
  } state_t;

endpackage

// File: rtl/game_countdown_timer_if.sv
// Control/status bundle between the game controller side and the countdown
// timer. The master side drives the pulses and the start value.
interface game_countdown_timer_if;
  import game_countdown_timer_pkg::*;

  logic               one_sec;
  logic               start;
  logic               abort;
  logic               hold;
  logic [7:0]         start_val;
  logic               timer_en;
  logic [DIGIT_W-1:0] sec_tens;
  logic [DIGIT_W-1:0] sec_ones;
  logic               running;
  logic               expired;
  logic               expire_pulse;

  modport master (
    output one_sec, start, abort, hold, start_val,
    input  timer_en, sec_tens, sec_ones, running, expired, expire_pulse
  );

  modport slave (
    input  one_sec, start, abort, hold, start_val,
    output timer_en, sec_tens, sec_ones, running, expired, expire_pulse
  );

endinterface

// File: rtl/game_countdown_timer_bcd_down_counter_2d.sv
// Two-digit BCD down counter with borrow; saturates at 00 so the tens digit
// can never underflow.
module bcd_down_counter_2d
  import game_countdown_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] DEFAULT_TENS = 4'd3,
  parameter logic [DIGIT_W-1:0] DEFAULT_ONES = 4'd0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_tens,
  input  logic [DIGIT_W-1:0] load_ones,
  input  logic               dec,
  output logic [DIGIT_W-1:0] tens,
  output logic [DIGIT_W-1:0] ones,
  output logic               zero
);

  assign zero = (tens == '0) && (ones == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens <= DEFAULT_TENS;
      ones <= DEFAULT_ONES;
    end else if (load) begin
      tens <= load_tens;
      ones <= load_ones;
    end else if (dec && !zero) begin
      if (ones != '0) begin
        ones <= ones - 1'b1;
      end else begin
        ones <= 4'd9;
        tens <= tens - 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_countdown_timer.sv
// Round countdown controller: FSM, start-value validation and registered
// status outputs around a two-digit BCD down counter.
module game_countdown_timer
  import game_countdown_timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] DEFAULT_TENS = 4'd3,
  parameter logic [DIGIT_W-1:0] DEFAULT_ONES = 4'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  game_countdown_timer_if.slave ifc
);

  state_t             state_q, state_n;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [DIGIT_W-1:0] cnt_tens, cnt_ones;
  logic [DIGIT_W-1:0] ld_tens, ld_ones;
  logic               timer_en_q, running_q, expired_q, expire_pulse_q;

  // Start values of 00 or with a non-BCD nibble fall back to the default round.
  function automatic logic start_val_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v != 8'h00);
  endfunction

  assign ld_tens = start_val_ok(ifc.start_val) ? ifc.start_val[7:4] : DEFAULT_TENS;
  assign ld_ones = start_val_ok(ifc.start_val) ? ifc.start_val[3:0] : DEFAULT_ONES;

  bcd_down_counter_2d #(
    .DEFAULT_TENS (DEFAULT_TENS),
    .DEFAULT_ONES (DEFAULT_ONES)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_tens (ld_tens),
    .load_ones (ld_ones),
    .dec       (cnt_dec),
    .tens      (cnt_tens),
    .ones      (cnt_ones),
    .zero      (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (ifc.abort) begin
      state_n = ST_IDLE;
    end else if (ifc.start) begin
      state_n  = ST_RUN;
      cnt_load = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ifc.hold) begin
            state_n = ST_PAUSE;
          end else if (ifc.one_sec) begin
            cnt_dec = 1'b1;
            // The edge that writes 00 is also the edge that enters EXPIRED.
            if (cnt_zero || (cnt_tens == '0 && cnt_ones == 4'd1))
              state_n = ST_EXPIRED;
          end
        end
        ST_PAUSE: begin
          if (!ifc.hold) state_n = ST_RUN;
        end
        default: state_n = state_q;
      endcase
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_en_q     <= 1'b0;
      running_q      <= 1'b0;
      expired_q      <= 1'b0;
      expire_pulse_q <= 1'b0;
    end else begin
      timer_en_q     <= (state_n == ST_RUN);
      running_q      <= (state_n == ST_RUN);
      expired_q      <= (state_n == ST_EXPIRED);
      expire_pulse_q <= (state_n == ST_EXPIRED) && (state_q != ST_EXPIRED);
    end
  end

  assign ifc.timer_en     = timer_en_q;
  assign ifc.running      = running_q;
  assign ifc.expired      = expired_q;
  assign ifc.expire_pulse = expire_pulse_q;
  assign ifc.sec_tens     = cnt_tens;
  assign ifc.sec_ones     = cnt_ones;

endmodule
